intl_latch_seq: RTL and testbench

- Interlock latch and reset sequencer for the MPS interlock path.
- Filters eight raw fault inputs: ext1-4, OC, POC, OV, OH.
- Applies PS bypass masks, latches faults sticky, and captures the first fault.
- On a PS clear request, runs a timed sequence: pulse the OC/POC hardware latch resets, wait for settling, re-check. Sits between the interlock pins and the AXI register block; its outputs feed the interlock state word.

---
 rtl/intl_latch_seq.sv | 206 ++++++++++++++++++++
 tb/tb_intl_latch_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intl_latch_seq.sv
// Interlock latch and clear sequencer: debounces eight raw fault pins, latches
// unmasked faults sticky, records the first fault, and on a PS clear request
// pulses the OC/POC hardware latch resets, waits for settling, then re-checks.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_intl_src[7:0]       raw faults (0-3 ext1-4, 4 OC, 5 POC, 6 OV, 7 OH)
//   i_intl_mask[7:0]      bypass mask, 1 = ignore source for latching/re-check
//   i_clr_req             single-cycle clear request (ignored while busy)
//   o_intl_OC_rst/POC_rst hardware latch reset pulses
//   o_intl_filt           debounced levels
//   o_intl_latched        sticky faults, o_intl_any = OR of them
//   o_first_fault         {valid, index} of the first latched source
//   o_busy                clear sequence running
//   o_clr_done/o_clr_fail one-cycle outcome pulses of the re-check
module intl_latch_seq #(
  parameter int unsigned DB_CNT    = 100,
  parameter int unsigned RST_PULSE = 1000,
  parameter int unsigned SETTLE    = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_intl_src,
  input  logic [7:0] i_intl_mask,
  input  logic       i_clr_req,
  output logic       o_intl_OC_rst,
  output logic       o_intl_POC_rst,
  output logic [7:0] o_intl_filt,
  output logic [7:0] o_intl_latched,
  output logic [3:0] o_first_fault,
  output logic       o_intl_any,
  output logic       o_busy,
  output logic       o_clr_done,
  output logic       o_clr_fail
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FAULT  = 3'd1,
    S_PULSE  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  localparam logic [15:0] DB_LAST     = 16'(DB_CNT - 1);
  localparam logic [19:0] PULSE_LAST  = 20'(RST_PULSE - 1);
  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE - 1);

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [7:0]       filt_q, filt_d;
  logic [7:0][15:0] db_cnt_q, db_cnt_d;

  // The counter only runs while raw disagrees with the filtered level; any
  // agreeing sample restarts it, so glitches shorter than DB_CNT die here.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_intl_src[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          filt_d[i] = i_intl_src[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latch, first fault and clear sequencer
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [7:0]  latched_q, latched_d;
  logic [3:0]  first_q, first_d;
  logic        any_q, any_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic [7:0]  active;
  logic [2:0]  lowest;

  assign active = filt_q & ~i_intl_mask;

  // Lowest set index of the currently active sources.
  always_comb begin
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) lowest = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    latched_d = latched_q | active;
    first_d   = first_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;

    // First fault is only captured from an empty latch, so later arrivals
    // never overwrite it until a successful clear.
    if ((latched_q == 8'd0) && (active != 8'd0)) begin
      first_d = {1'b1, lowest};
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_clr_req) begin
          state_d = S_PULSE;
          timer_d = '0;
        end else if (latched_q != 8'd0) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (i_clr_req) begin
          state_d = S_PULSE;
          timer_d = '0;
        end
      end
      S_PULSE: begin
        if (timer_q == PULSE_LAST) begin
          state_d = S_SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      S_CHECK: begin
        timer_d = '0;
        // Judged on the present debounced level: a fault that latched during
        // the sequence but has since gone away does not block the clear.
        if (active == 8'd0) begin
          latched_d = '0;
          first_d   = '0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          fail_d    = 1'b1;
          state_d   = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    any_d = |latched_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      latched_q <= '0;
      first_q   <= '0;
      any_q     <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      latched_q <= latched_d;
      first_q   <= first_d;
      any_q     <= any_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  // Decoded straight from the state register so an async reset drops the
  // hardware latch resets immediately.
  assign o_intl_OC_rst  = (state_q == S_PULSE);
  assign o_intl_POC_rst = (state_q == S_PULSE);
  assign o_busy         = (state_q == S_PULSE) || (state_q == S_SETTLE) ||
                          (state_q == S_CHECK);
  assign o_intl_filt    = filt_q;
  assign o_intl_latched = latched_q;
  assign o_first_fault  = first_q;
  assign o_intl_any     = any_q;
  assign o_clr_done     = done_q;
  assign o_clr_fail     = fail_q;

endmodule

// File: tb/tb_intl_latch_seq.sv
// Bench for intl_latch_seq with DB_CNT=4, RST_PULSE=8, SETTLE=16.
module tb_intl_latch_seq;

  localparam int DB = 4;
  localparam int RP = 8;
  localparam int ST = 16;
  // Edges from the one sampling i_clr_req up to the one registering the
  // outcome pulse: PULSE + SETTLE + CHECK + the request edge itself.
  localparam int EXP_CYC = RP + ST + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic [7:0] mask;
  logic       clr;
  logic       oc_rst, poc_rst, any, busy, done, fail;
  logic [7:0] filt, latched;
  logic [3:0] ff;

  intl_latch_seq #(.DB_CNT(DB), .RST_PULSE(RP), .SETTLE(ST)) dut (
    .i_clk(clk), .i_rst(rst), .i_intl_src(src), .i_intl_mask(mask),
    .i_clr_req(clr), .o_intl_OC_rst(oc_rst), .o_intl_POC_rst(poc_rst),
    .o_intl_filt(filt), .o_intl_latched(latched), .o_first_fault(ff),
    .o_intl_any(any), .o_busy(busy), .o_clr_done(done), .o_clr_fail(fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic       fail;
    logic [7:0] latched;
    logic [3:0] ff;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1; src = '0; mask = '0; clr = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  // Issues a clear request and runs until the outcome pulse appears, reporting
  // what it observed; comparisons are left to the calling scenario.
  task automatic run_clear(input int extra_at, output int cyc, output int rst_hi,
                           output bit busy_start, output bit seen, output exp_t obs);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cyc = 1; rst_hi = 0; seen = 1'b0; obs = '0;
    busy_start = busy;
    for (int k = 0; k < 200; k++) begin
      if (oc_rst && poc_rst) rst_hi++;
      if (done || fail) begin
        seen = 1'b1;
        obs  = '{done: done, fail: fail, latched: latched, ff: ff, busy: busy};
        break;
      end
      if (cyc == extra_at) clr = 1'b1;
      tick();
      clr = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; src = '0; mask = '0; clr = 1'b0;
    #2;
    n_checks++;
    if ({oc_rst, poc_rst, busy, done, fail, any} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000", {oc_rst, poc_rst, busy, done, fail, any});
    end
    n_checks++;
    if ({filt, latched, ff} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_data: got filt=%h latched=%h ff=%h required 0", filt, latched, ff);
    end
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_glitch();
    src = 8'h10;
    ticks(DB - 1);
    src = 8'h00;
    ticks(6);
    n_checks++;
    if (filt !== 8'h00) begin
      n_fail++; $display("FAIL glitch_filt: got %h required 00", filt);
    end
    n_checks++;
    if ({latched, any, busy} !== 10'h0) begin
      n_fail++; $display("FAIL glitch_latch: got latched=%h any=%b busy=%b required 0", latched, any, busy);
    end
  endtask

  task automatic test_debounce_latch();
    src = 8'h40;
    ticks(DB - 1);
    n_checks++;
    if (filt !== 8'h00) begin
      n_fail++; $display("FAIL db_early: got %h required 00", filt);
    end
    tick();
    n_checks++;
    if (filt !== 8'h40 || latched !== 8'h00) begin
      n_fail++; $display("FAIL db_edge: got filt=%h latched=%h required 40/00", filt, latched);
    end
    tick();
    n_checks++;
    if (latched !== 8'h40 || any !== 1'b1 || ff !== 4'b1110) begin
      n_fail++;
      $display("FAIL latch_bit6: got latched=%h any=%b ff=%b required 40/1/1110", latched, any, ff);
    end
  endtask

  task automatic test_clear_fail();
    int cyc, rst_hi; bit bs, seen; exp_t obs, e;
    sb.push_back('{done: 1'b0, fail: 1'b1, latched: 8'h40, ff: 4'b1110, busy: 1'b0});
    run_clear(-1, cyc, rst_hi, bs, seen, obs);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL clr_fail_timeout: no outcome pulse within bound");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_fail++; $display("FAIL clr_fail_outcome: got %h required %h", obs, e);
      end
    end
    n_checks++;
    if (cyc !== EXP_CYC || rst_hi !== RP || bs !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_fail_timing: got cyc=%0d rst_hi=%0d busy=%b required %0d/%0d/1", cyc, rst_hi, bs, EXP_CYC, RP);
    end
    tick();
    n_checks++;
    if (fail !== 1'b0 || latched !== 8'h40) begin
      n_fail++; $display("FAIL clr_fail_after: got fail=%b latched=%h required 0/40", fail, latched);
    end
  endtask

  task automatic test_clear_ok();
    int cyc, rst_hi; bit bs, seen; exp_t obs, e;
    src = 8'h00;
    ticks(DB + 1);
    n_checks++;
    if (filt !== 8'h00 || latched !== 8'h40) begin
      n_fail++; $display("FAIL sticky: got filt=%h latched=%h required 00/40", filt, latched);
    end
    sb.push_back('{done: 1'b1, fail: 1'b0, latched: 8'h00, ff: 4'b0000, busy: 1'b0});
    // Second request lands mid-SETTLE and must not stretch the sequence.
    run_clear(12, cyc, rst_hi, bs, seen, obs);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL clr_ok_timeout: no outcome pulse within bound");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_fail++; $display("FAIL clr_ok_outcome: got %h required %h", obs, e);
      end
    end
    n_checks++;
    if (cyc !== EXP_CYC || rst_hi !== RP) begin
      n_fail++; $display("FAIL clr_ok_timing: got cyc=%0d rst_hi=%0d required %0d/%0d", cyc, rst_hi, EXP_CYC, RP);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || any !== 1'b0) begin
      n_fail++; $display("FAIL clr_ok_after: got done=%b busy=%b any=%b required 0/0/0", done, busy, any);
    end
  endtask

  task automatic test_mask_clear();
    int cyc, rst_hi; bit bs, seen; exp_t obs, e;
    src = 8'h40;
    ticks(DB + 1);
    n_checks++;
    if (latched !== 8'h40 || ff !== 4'b1110) begin
      n_fail++; $display("FAIL relatch: got latched=%h ff=%b required 40/1110", latched, ff);
    end
    sb.push_back('{done: 1'b0, fail: 1'b1, latched: 8'h40, ff: 4'b1110, busy: 1'b0});
    run_clear(-1, cyc, rst_hi, bs, seen, obs);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL mask_fail_timeout: no outcome pulse within bound");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_fail++; $display("FAIL mask_fail_outcome: got %h required %h", obs, e);
      end
    end
    mask = 8'h40;
    ticks(2);
    n_checks++;
    if (latched !== 8'h40) begin
      n_fail++; $display("FAIL mask_keeps: got latched=%h required 40", latched);
    end
    sb.push_back('{done: 1'b1, fail: 1'b0, latched: 8'h00, ff: 4'b0000, busy: 1'b0});
    run_clear(-1, cyc, rst_hi, bs, seen, obs);
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL mask_ok_timeout: no outcome pulse within bound");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_fail++; $display("FAIL mask_ok_outcome: got %h required %h", obs, e);
      end
    end
    ticks(3);
    n_checks++;
    if (latched !== 8'h00 || filt !== 8'h40) begin
      n_fail++; $display("FAIL mask_no_relatch: got latched=%h filt=%h required 00/40", latched, filt);
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    src = 8'h24;
    ticks(DB + 1);
    n_checks++;
    if (latched !== 8'h24 || ff !== 4'b1010 || any !== 1'b1) begin
      n_fail++; $display("FAIL simul: got latched=%h ff=%b any=%b required 24/1010/1", latched, ff, any);
    end
  endtask

  task automatic test_reset_mid();
    src = 8'h00;
    ticks(DB + 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ticks(2);
    n_checks++;
    if (oc_rst !== 1'b1 || poc_rst !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pulse: got oc=%b poc=%b busy=%b required 1/1/1", oc_rst, poc_rst, busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({oc_rst, poc_rst, busy, done, fail, any} !== 6'b0 || {filt, latched, ff} !== 20'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got ctrl=%b latched=%h ff=%b required all 0", {oc_rst, poc_rst, busy, done, fail, any}, latched, ff);
    end
    tick();
    rst = 1'b0;
    ticks(3);
    n_checks++;
    if (busy !== 1'b0 || oc_rst !== 1'b0 || latched !== 8'h00) begin
      n_fail++; $display("FAIL mid_idle: got busy=%b oc=%b latched=%h required 0/0/00", busy, oc_rst, latched);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_debounce_latch();
    test_clear_fail();
    test_clear_ok();
    test_mask_clear();
    test_simultaneous();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
